// File: rtl/id_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_hazard_ctrl
// Purpose : Sequencing controller for the dual-issue ID/EX pipeline register.
//           Detects load-use hazards between the EX-stage load and the five
//           ID-stage source registers and inserts LOAD_LAT bubble cycles.
//           Flushes IF/ID for FLUSH_CYC cycles on a taken branch. A global
//           hold freezes the pipeline and all controller state.
// Ports   : i_clk, i_reset (async, active-high), i_ext_hold, i_id_valid,
//           i_id_i1_Rd/Rm, i_id_i2_Rd/Rm/Rn (ID source indices),
//           i_ex_memRead, i_ex_Rd (EX load destination), i_branch_taken,
//           o_idex_regWrite, o_idex_bubble, o_ifid_stall, o_ifid_flush,
//           o_stall_count/o_flush_count (PERF_CNT_EN only).
// Config  : define PERF_CNT_EN to add the 16-bit saturating perf counters.
// Revision: 1.0  initial release
// ============================================================================
module id_ex_hazard_ctrl #(
  parameter int REG_W     = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ext_hold,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_i1_Rd,
  input  logic [REG_W-1:0] i_id_i1_Rm,
  input  logic [REG_W-1:0] i_id_i2_Rd,
  input  logic [REG_W-1:0] i_id_i2_Rm,
  input  logic [REG_W-1:0] i_id_i2_Rn,
  input  logic             i_ex_memRead,
  input  logic [REG_W-1:0] i_ex_Rd,
  input  logic             i_branch_taken,
  output logic             o_idex_regWrite,
  output logic             o_idex_bubble,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]      o_stall_count,
  output logic [15:0]      o_flush_count
`endif
);

  localparam logic [1:0] c_RUN   = 2'd0;
  localparam logic [1:0] c_STALL = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;

  // Initial cnt values: the first bubble cycle is spent in RUN, so the
  // counted state only covers the remaining LAT-1 cycles.
  localparam logic [1:0] c_STALL_INIT = (LOAD_LAT  > 1) ? 2'(LOAD_LAT  - 2) : 2'd0;
  localparam logic [1:0] c_FLUSH_INIT = (FLUSH_CYC > 1) ? 2'(FLUSH_CYC - 2) : 2'd0;

  logic [1:0] r_state;
  logic [1:0] r_cnt;
  logic [1:0] w_state_nxt;
  logic [1:0] w_cnt_nxt;
  logic       w_hazard;

  // Register 0 is an ordinary index here; no zero-register exemption.
  assign w_hazard = i_id_valid & i_ex_memRead &
                    ((i_ex_Rd == i_id_i1_Rd) | (i_ex_Rd == i_id_i1_Rm) |
                     (i_ex_Rd == i_id_i2_Rd) | (i_ex_Rd == i_id_i2_Rm) |
                     (i_ex_Rd == i_id_i2_Rn));

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= c_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. Hold freezes everything; a taken branch overrides and
  // cancels any stall in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_ext_hold) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
    end else if (i_branch_taken) begin
      w_state_nxt = (FLUSH_CYC > 1) ? c_FLUSH : c_RUN;
      w_cnt_nxt   = c_FLUSH_INIT;
    end else begin
      case (r_state)
        c_RUN: begin
          if (w_hazard && (LOAD_LAT > 1)) begin
            w_state_nxt = c_STALL;
            w_cnt_nxt   = c_STALL_INIT;
          end
        end
        c_STALL, c_FLUSH: begin
          if (r_cnt == 2'd0) begin
            w_state_nxt = c_RUN;
          end else begin
            w_cnt_nxt = r_cnt - 2'd1;
          end
        end
        default: begin
          w_state_nxt = c_RUN;
          w_cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Mealy outputs. Reset is folded in combinationally so the outputs react
  // as soon as reset rises, without waiting for a clock edge.
  always_comb begin
    o_idex_regWrite = 1'b1;
    o_idex_bubble   = 1'b0;
    o_ifid_stall    = 1'b0;
    o_ifid_flush    = 1'b0;
    if (i_reset) begin
      o_idex_regWrite = 1'b0;
      o_idex_bubble   = 1'b1;
    end else if (i_ext_hold) begin
      o_idex_regWrite = 1'b0;
      o_ifid_stall    = 1'b1;
    end else if (i_branch_taken) begin
      o_idex_bubble = 1'b1;
      o_ifid_flush  = 1'b1;
    end else begin
      case (r_state)
        c_RUN: begin
          if (w_hazard) begin
            o_idex_bubble = 1'b1;
            o_ifid_stall  = 1'b1;
          end
        end
        c_STALL: begin
          o_idex_bubble = 1'b1;
          o_ifid_stall  = 1'b1;
        end
        c_FLUSH: begin
          o_idex_bubble = 1'b1;
          o_ifid_flush  = 1'b1;
        end
        default: begin
          o_idex_bubble = 1'b1;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  // Outside hold, ifid_stall is only ever raised by a load-use hazard.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else if (!i_ext_hold) begin
      if (o_ifid_stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (o_ifid_flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_hazard_ctrl
// Purpose : Directed self-checking bench. Two instances share one stimulus:
//           u_dut_a with LOAD_LAT=1, u_dut_b with LOAD_LAT=3; both FLUSH_CYC=2.
//           Output vectors are packed {regWrite, bubble, stall, flush}.
// Revision: 1.0  initial release
// ============================================================================
module tb_id_ex_hazard_ctrl;

  localparam logic [3:0] c_NORM = 4'b1000;
  localparam logic [3:0] c_HAZ  = 4'b1110;
  localparam logic [3:0] c_FLU  = 4'b1101;
  localparam logic [3:0] c_HOLD = 4'b0010;
  localparam logic [3:0] c_RST  = 4'b0100;

  logic       clk;
  logic       reset;
  logic       ext_hold;
  logic       id_valid;
  logic [2:0] i1_Rd, i1_Rm, i2_Rd, i2_Rm, i2_Rn;
  logic       ex_memRead;
  logic [2:0] ex_Rd;
  logic       branch_taken;

  logic a_rw, a_bub, a_st, a_fl;
  logic b_rw, b_bub, b_st, b_fl;
`ifdef PERF_CNT_EN
  logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  id_ex_hazard_ctrl #(.REG_W(3), .LOAD_LAT(1), .FLUSH_CYC(2)) u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_ext_hold(ext_hold), .i_id_valid(id_valid),
    .i_id_i1_Rd(i1_Rd), .i_id_i1_Rm(i1_Rm), .i_id_i2_Rd(i2_Rd),
    .i_id_i2_Rm(i2_Rm), .i_id_i2_Rn(i2_Rn), .i_ex_memRead(ex_memRead),
    .i_ex_Rd(ex_Rd), .i_branch_taken(branch_taken),
    .o_idex_regWrite(a_rw), .o_idex_bubble(a_bub),
    .o_ifid_stall(a_st), .o_ifid_flush(a_fl)
`ifdef PERF_CNT_EN
    , .o_stall_count(a_scnt), .o_flush_count(a_fcnt)
`endif
  );

  id_ex_hazard_ctrl #(.REG_W(3), .LOAD_LAT(3), .FLUSH_CYC(2)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_ext_hold(ext_hold), .i_id_valid(id_valid),
    .i_id_i1_Rd(i1_Rd), .i_id_i1_Rm(i1_Rm), .i_id_i2_Rd(i2_Rd),
    .i_id_i2_Rm(i2_Rm), .i_id_i2_Rn(i2_Rn), .i_ex_memRead(ex_memRead),
    .i_ex_Rd(ex_Rd), .i_branch_taken(branch_taken),
    .o_idex_regWrite(b_rw), .o_idex_bubble(b_bub),
    .o_ifid_stall(b_st), .o_ifid_flush(b_fl)
`ifdef PERF_CNT_EN
    , .o_stall_count(b_scnt), .o_flush_count(b_fcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle before sampling.
  task automatic settle();
    #3;
  endtask

  function automatic logic [31:0] va();
    return {28'd0, a_rw, a_bub, a_st, a_fl};
  endfunction

  function automatic logic [31:0] vb();
    return {28'd0, b_rw, b_bub, b_st, b_fl};
  endfunction

  task automatic quiet();
    ext_hold     = 1'b0;
    id_valid     = 1'b1;
    i1_Rd = 3'd1; i1_Rm = 3'd2; i2_Rd = 3'd4; i2_Rm = 3'd5; i2_Rn = 3'd6;
    ex_memRead   = 1'b0;
    ex_Rd        = 3'd7;
    branch_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    #2;
    chk("reset_a", va(), {28'd0, c_RST});
    chk("reset_b", vb(), {28'd0, c_RST});
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("idle_a", va(), {28'd0, c_NORM});
    chk("idle_b", vb(), {28'd0, c_NORM});

    // T1/T2: load to r3, i2 reads r3
    tick();
    ex_memRead = 1'b1; ex_Rd = 3'd3; i2_Rn = 3'd3;
    settle();
    chk("t1_haz_a", va(), {28'd0, c_HAZ});
    chk("t2_haz_b0", vb(), {28'd0, c_HAZ});
    tick();
    ex_memRead = 1'b0;
    settle();
    chk("t1_norm_a", va(), {28'd0, c_NORM});
    chk("t2_haz_b1", vb(), {28'd0, c_HAZ});
    tick(); settle();
    chk("t2_haz_b2", vb(), {28'd0, c_HAZ});
    tick(); settle();
    chk("t2_norm_b", vb(), {28'd0, c_NORM});
`ifdef PERF_CNT_EN
    chk("t1_scnt_a", {16'd0, a_scnt}, 32'd1);
    chk("t2_scnt_b", {16'd0, b_scnt}, 32'd3);
`endif
    quiet();

    // T3: single-cycle taken branch
    tick();
    branch_taken = 1'b1;
    settle();
    chk("t3_flu0", vb(), {28'd0, c_FLU});
    tick();
    branch_taken = 1'b0;
    settle();
    chk("t3_flu1", vb(), {28'd0, c_FLU});
    tick(); settle();
    chk("t3_norm", vb(), {28'd0, c_NORM});
`ifdef PERF_CNT_EN
    chk("t3_fcnt_b", {16'd0, b_fcnt}, 32'd2);
`endif

    // T4: branch in 2nd cycle of a 3-cycle stall
    tick();
    ex_memRead = 1'b1; ex_Rd = 3'd5;
    settle();
    chk("t4_haz0", vb(), {28'd0, c_HAZ});
    tick();
    ex_memRead = 1'b0; branch_taken = 1'b1;
    settle();
    chk("t4_flu0", vb(), {28'd0, c_FLU});
    tick();
    branch_taken = 1'b0;
    settle();
    chk("t4_flu1", vb(), {28'd0, c_FLU});
    tick(); settle();
    chk("t4_norm", vb(), {28'd0, c_NORM});
`ifdef PERF_CNT_EN
    chk("t4_scnt_b", {16'd0, b_scnt}, 32'd4);
    chk("t4_fcnt_b", {16'd0, b_fcnt}, 32'd4);
`endif

    // T5: hold for 4 cycles in the middle of a stall
    tick();
    ex_memRead = 1'b1; ex_Rd = 3'd1;
    settle();
    chk("t5_haz0", vb(), {28'd0, c_HAZ});
    tick();
    ex_memRead = 1'b0; ext_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t5_hold%0d", i), vb(), {28'd0, c_HOLD});
      tick();
    end
    ext_hold = 1'b0;
    settle();
    chk("t5_haz1", vb(), {28'd0, c_HAZ});
    tick(); settle();
    chk("t5_haz2", vb(), {28'd0, c_HAZ});
    tick(); settle();
    chk("t5_norm", vb(), {28'd0, c_NORM});
`ifdef PERF_CNT_EN
    chk("t5_scnt_b", {16'd0, b_scnt}, 32'd7);
`endif

    // Hazard qualifiers on the single-cycle instance
    tick();
    ex_memRead = 1'b1; ex_Rd = 3'd3;
    settle();
    chk("nomatch_a", va(), {28'd0, c_NORM});
    tick();
    ex_Rd = 3'd2; id_valid = 1'b0;
    settle();
    chk("novalid_a", va(), {28'd0, c_NORM});
    tick();
    id_valid = 1'b1; ex_Rd = 3'd0; i1_Rd = 3'd0;
    settle();
    chk("reg0_a", va(), {28'd0, c_HAZ});
    tick();
    quiet();
    tick(); tick(); tick();

    // T6: async reset between edges during FLUSH
    branch_taken = 1'b1;
    settle();
    chk("t6_flu0", vb(), {28'd0, c_FLU});
    tick();
    branch_taken = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_b", vb(), {28'd0, c_RST});
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_run_b", vb(), {28'd0, c_NORM});
    chk("t6_run_a", va(), {28'd0, c_NORM});
`ifdef PERF_CNT_EN
    chk("t6_scnt_b", {16'd0, b_scnt}, 32'd0);
    chk("t6_fcnt_b", {16'd0, b_fcnt}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
